// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg: shared mode encoding, channel FSM states and mode decoding
package motor_pwm_pkg;

    typedef enum logic [1:0] {
        COAST = 2'b00,
        DRIVE = 2'b01,
        BRAKE = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        SETTLED,
        RAMP_UP,
        RAMP_DN,
        REVERSE
    } state_t;

    function automatic mode_t norm_mode(input logic [1:0] m);
        return m == 2'b01 ? DRIVE : m == 2'b10 ? BRAKE : COAST;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: shadow/target registers, ramp FSM and H-bridge output mapping for one motor
module pwm_channel
    import motor_pwm_pkg::*;
#(
    parameter int DUTY_W    = 4,
    parameter int RAMP_STEP = 1
) (
    input  logic              clk_50M,
    input  logic              reset,
    input  logic              load,
    input  logic              estop,
    input  logic              period_tick,
    input  logic [DUTY_W-1:0] cnt,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              dir_in,
    input  logic [1:0]        mode_in,
    output logic              pwm_a,
    output logic              pwm_b,
    output logic              busy,
    output logic [DUTY_W-1:0] duty_cur
);

    localparam logic [DUTY_W:0] STEP_W = (DUTY_W + 1)'(RAMP_STEP);

    logic [DUTY_W-1:0] sh_duty, tg_duty, nt_duty, n_duty, up, dn, rv;
    logic              sh_dir, tg_dir, nt_dir, dir_cur, n_dir, pend, held, raw;
    mode_t             sh_mode, tg_mode, nt_mode, mode_cur, n_mode;
    state_t            state, n_state;
    logic [DUTY_W:0]   gap_up, gap_dn;

    assign nt_duty = pend ? sh_duty : tg_duty;
    assign nt_dir  = pend ? sh_dir : tg_dir;
    assign nt_mode = pend ? sh_mode : tg_mode;
    assign gap_up  = {1'b0, nt_duty} - {1'b0, duty_cur};
    assign gap_dn  = {1'b0, duty_cur} - {1'b0, nt_duty};
    assign up      = gap_up > STEP_W ? duty_cur + STEP_W[DUTY_W-1:0] : nt_duty;
    assign dn      = gap_dn > STEP_W ? duty_cur - STEP_W[DUTY_W-1:0] : nt_duty;
    assign rv      = {1'b0, duty_cur} > STEP_W ? duty_cur - STEP_W[DUTY_W-1:0] : '0;
    assign raw     = cnt < duty_cur;
    assign pwm_a   = mode_cur == BRAKE || (mode_cur == DRIVE && !dir_cur && raw);
    assign pwm_b   = mode_cur == BRAKE || (mode_cur == DRIVE && dir_cur && raw);
    assign busy    = state != SETTLED;

    // next-period decision: coast/brake apply at once, reversal ramps to zero before flipping dir
    always_comb begin
        n_state = state;
        n_duty  = duty_cur;
        n_dir   = dir_cur;
        n_mode  = mode_cur;
        if (nt_mode != DRIVE) begin
            n_mode  = nt_mode;
            n_duty  = '0;
            n_dir   = nt_dir;
            n_state = SETTLED;
        end else if (nt_dir != dir_cur && duty_cur != '0) begin
            n_mode  = DRIVE;
            n_duty  = rv;
            n_dir   = rv == '0 ? nt_dir : dir_cur;
            n_state = rv != '0 ? REVERSE : nt_duty == '0 ? SETTLED : RAMP_UP;
        end else begin
            n_mode  = DRIVE;
            n_dir   = nt_dir;
            n_duty  = duty_cur < nt_duty ? up : duty_cur > nt_duty ? dn : duty_cur;
            n_state = n_duty < nt_duty ? RAMP_UP : n_duty > nt_duty ? RAMP_DN : SETTLED;
        end
    end

    // state, shadow and target registers; estop brakes and clears, release falls back to coast
    always_ff @(posedge clk_50M) begin
        if (reset || estop) begin
            sh_duty  <= '0;
            sh_dir   <= 1'b0;
            sh_mode  <= COAST;
            tg_duty  <= '0;
            tg_dir   <= 1'b0;
            tg_mode  <= COAST;
            pend     <= 1'b0;
            duty_cur <= '0;
            dir_cur  <= 1'b0;
            mode_cur <= reset ? COAST : BRAKE;
            state    <= SETTLED;
            held     <= !reset;
        end else begin
            if (load) begin
                sh_duty <= duty_in;
                sh_dir  <= dir_in;
                sh_mode <= norm_mode(mode_in);
            end
            pend <= load || (pend && !period_tick);
            held <= 1'b0;
            if (period_tick) begin
                tg_duty  <= nt_duty;
                tg_dir   <= nt_dir;
                tg_mode  <= nt_mode;
                duty_cur <= n_duty;
                dir_cur  <= n_dir;
                mode_cur <= n_mode;
                state    <= n_state;
            end else if (held) begin
                mode_cur <= COAST;
            end
        end
    end

endmodule

// File: rtl/motor_pwm_array.sv
// motor_pwm_array: shared prescaler/period counter driving N_CH ramped H-bridge PWM channels
module motor_pwm_array
    import motor_pwm_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int DUTY_W    = 4,
    parameter int PRESCALE  = 16,
    parameter int RAMP_STEP = 1
) (
    input  logic                   clk_50M,
    input  logic                   reset,
    input  logic [N_CH*DUTY_W-1:0] duty_in,
    input  logic [N_CH-1:0]        dir_in,
    input  logic [2*N_CH-1:0]      mode_in,
    input  logic                   load,
    input  logic                   estop,
    output logic                   load_ack,
    output logic [N_CH-1:0]        pwm_a,
    output logic [N_CH-1:0]        pwm_b,
    output logic [N_CH*DUTY_W-1:0] duty_cur,
    output logic                   period_tick,
    output logic                   busy
);

    localparam int                PW      = $clog2(PRESCALE);
    localparam logic [DUTY_W-1:0] CNT_MAX = {{(DUTY_W - 1){1'b1}}, 1'b0};

    logic [PW-1:0]     presc;
    logic [DUTY_W-1:0] cnt;
    logic [N_CH-1:0]   busy_v;
    logic              tick;

    assign tick        = presc == PW'(PRESCALE - 1);
    assign period_tick = tick && cnt == CNT_MAX;
    assign busy        = |busy_v;

    // prescaler, period counter and load acknowledge
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            presc    <= '0;
            cnt      <= '0;
            load_ack <= 1'b0;
        end else begin
            presc    <= tick ? '0 : presc + 1'b1;
            load_ack <= load && !estop;
            if (tick) cnt <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        pwm_channel #(
            .DUTY_W   (DUTY_W),
            .RAMP_STEP(RAMP_STEP)
        ) u_ch (
            .clk_50M    (clk_50M),
            .reset      (reset),
            .load       (load && !estop),
            .estop      (estop),
            .period_tick(period_tick),
            .cnt        (cnt),
            .duty_in    (duty_in[k*DUTY_W+:DUTY_W]),
            .dir_in     (dir_in[k]),
            .mode_in    (mode_in[2*k+:2]),
            .pwm_a      (pwm_a[k]),
            .pwm_b      (pwm_b[k]),
            .busy       (busy_v[k]),
            .duty_cur   (duty_cur[k*DUTY_W+:DUTY_W])
        );
    end

endmodule

// File: tb/tb_motor_pwm_array.sv
// tb_motor_pwm_array: vector table plus ramp scoreboards for the default and a wide configuration
module tb_motor_pwm_array;

    typedef struct {
        logic [1:0] m;
        logic       r;
        logic [3:0] d;
        logic [3:0] dc;
        logic       a;
        logic       b;
    } vec_t;

    typedef struct {
        logic [3:0] dc;
        logic       a;
        logic       b;
    } exp_t;

    logic        clk_50M = 1'b0;
    logic        reset, load, estop, load_ack, period_tick, busy;
    logic [7:0]  duty_in, duty_cur;
    logic [1:0]  dir_in, pwm_a, pwm_b;
    logic [3:0]  mode_in;
    logic        b_load, b_estop, b_ack, b_tick, b_busy;
    logic [31:0] b_duty, b_cur;
    logic [3:0]  b_dir, b_a, b_b;
    logic [7:0]  b_mode;
    int          tests = 0, fails = 0, ov = 0;
    bit          ov_en = 1'b0;
    exp_t        q0[$], q1[$];
    int          bq[$];

    always #10 clk_50M = ~clk_50M;

    motor_pwm_array u_dut (
        .clk_50M(clk_50M), .reset(reset), .duty_in(duty_in), .dir_in(dir_in), .mode_in(mode_in),
        .load(load), .estop(estop), .load_ack(load_ack), .pwm_a(pwm_a), .pwm_b(pwm_b),
        .duty_cur(duty_cur), .period_tick(period_tick), .busy(busy)
    );

    motor_pwm_array #(.N_CH(4), .DUTY_W(8), .PRESCALE(2), .RAMP_STEP(16)) u_big (
        .clk_50M(clk_50M), .reset(reset), .duty_in(b_duty), .dir_in(b_dir), .mode_in(b_mode),
        .load(b_load), .estop(b_estop), .load_ack(b_ack), .pwm_a(b_a), .pwm_b(b_b),
        .duty_cur(b_cur), .period_tick(b_tick), .busy(b_busy)
    );

    always @(negedge clk_50M) if (ov_en && (pwm_a & pwm_b) != 2'b00) ov++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        while (!period_tick && n < 300) begin
            @(negedge clk_50M);
            n++;
        end
        if (!period_tick) chk("period_tick_timeout", period_tick, 1);
        @(negedge clk_50M);
    endtask

    task automatic do_load(input logic [7:0] d, input logic [1:0] r, input logic [3:0] m);
        duty_in = d;
        dir_in  = r;
        mode_in = m;
        load    = 1'b1;
        @(negedge clk_50M);
        load = 1'b0;
        chk("load_ack", load_ack, 1);
        @(negedge clk_50M);
        chk("load_ack_pulse", load_ack, 0);
    endtask

    task automatic pop_ch(input int ch);
        exp_t e;
        wait_tick();
        e = ch != 0 ? q1.pop_front() : q0.pop_front();
        chk($sformatf("ch%0d_duty", ch), duty_cur[ch*4+:4], e.dc);
        chk($sformatf("ch%0d_a", ch), pwm_a[ch], e.a);
        chk($sformatf("ch%0d_b", ch), pwm_b[ch], e.b);
    endtask

    initial begin
        vec_t vt[8];
        exp_t e;
        int   hi, n, ev;
        vt[0] = '{2'd0, 1'b0, 4'd5, 4'd0, 1'b0, 1'b0};
        vt[1] = '{2'd1, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0};
        vt[2] = '{2'd2, 1'b0, 4'd7, 4'd0, 1'b1, 1'b1};
        vt[3] = '{2'd1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b1};
        vt[4] = '{2'd3, 1'b1, 4'd9, 4'd0, 1'b0, 1'b0};
        vt[5] = '{2'd1, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0};
        vt[6] = '{2'd1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        vt[7] = '{2'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
        reset = 1'b1; load = 1'b0; estop = 1'b0; duty_in = '0; dir_in = '0; mode_in = '0;
        b_load = 1'b0; b_estop = 1'b0; b_duty = '0; b_dir = '0; b_mode = '0;
        repeat (3) @(negedge clk_50M);
        chk("rst_pwm_a", pwm_a, 0);
        chk("rst_pwm_b", pwm_b, 0);
        chk("rst_duty", duty_cur, 0);
        chk("rst_ack", load_ack, 0);
        chk("rst_tick", period_tick, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        foreach (vt[i]) begin
            do_load({4'h0, vt[i].d}, {1'b0, vt[i].r}, {2'b00, vt[i].m});
            wait_tick();
            chk($sformatf("vec%0d_duty", i), duty_cur[3:0], vt[i].dc);
            chk($sformatf("vec%0d_a", i), pwm_a[0], vt[i].a);
            chk($sformatf("vec%0d_b", i), pwm_b[0], vt[i].b);
            chk($sformatf("vec%0d_busy", i), busy, 0);
        end
        do_load(8'h0F, 2'b00, 4'b0001);
        for (int v = 1; v <= 15; v++) begin
            e = '{4'(v), 1'b1, 1'b0};
            q0.push_back(e);
        end
        pop_ch(0);
        chk("ramp_busy", busy, 1);
        while (q0.size() > 0) pop_ch(0);
        chk("full_settled_busy", busy, 0);
        hi = 0;
        repeat (240) begin
            @(negedge clk_50M);
            if (pwm_a[0] !== 1'b1 || pwm_b[0] !== 1'b0) hi++;
        end
        chk("ch0_full_on_glitches", hi, 0);
        ov_en = 1'b1;
        do_load({4'd8, 4'hF}, 2'b00, 4'b0101);
        for (int v = 1; v <= 8; v++) begin
            e = '{4'(v), 1'b1, 1'b0};
            q1.push_back(e);
        end
        while (q1.size() > 0) pop_ch(1);
        do_load({4'd4, 4'hF}, 2'b10, 4'b0101);
        for (int v = 7; v >= 1; v--) begin
            e = '{4'(v), 1'b1, 1'b0};
            q1.push_back(e);
        end
        e = '{4'd0, 1'b0, 1'b0};
        q1.push_back(e);
        for (int v = 1; v <= 4; v++) begin
            e = '{4'(v), 1'b0, 1'b1};
            q1.push_back(e);
        end
        while (q1.size() > 0) pop_ch(1);
        ov_en = 1'b0;
        chk("a_b_overlap_count", ov, 0);
        chk("ch0_kept", duty_cur[3:0], 15);
        do_load({4'd4, 4'd3}, 2'b10, 4'b0101);
        do_load({4'd4, 4'd9}, 2'b10, 4'b0101);
        for (int v = 14; v >= 9; v--) begin
            e = '{4'(v), 1'b1, 1'b0};
            q0.push_back(e);
        end
        while (q0.size() > 0) pop_ch(0);
        chk("latest_wins_busy", busy, 0);
        wait_tick();
        chk("latest_wins_hold", duty_cur[3:0], 9);
        do_load({4'd12, 4'd9}, 2'b10, 4'b0101);
        e = '{4'd5, 1'b0, 1'b1};
        q1.push_back(e);
        e = '{4'd6, 1'b0, 1'b1};
        q1.push_back(e);
        while (q1.size() > 0) pop_ch(1);
        chk("pre_estop_busy", busy, 1);
        estop = 1'b1;
        @(negedge clk_50M);
        chk("estop_a", pwm_a, 2'b11);
        chk("estop_b", pwm_b, 2'b11);
        chk("estop_duty", duty_cur, 0);
        chk("estop_busy", busy, 0);
        hi = 0;
        repeat (300) begin
            @(negedge clk_50M);
            if (pwm_a !== 2'b11 || pwm_b !== 2'b11 || duty_cur !== 8'h00) hi++;
        end
        chk("estop_hold_errors", hi, 0);
        estop = 1'b0;
        @(negedge clk_50M);
        chk("release_a", pwm_a, 0);
        chk("release_b", pwm_b, 0);
        wait_tick();
        chk("release_tick_a", pwm_a, 0);
        chk("release_tick_b", pwm_b, 0);
        chk("release_tick_duty", duty_cur, 0);
        estop = 1'b1; load = 1'b1; duty_in = 8'hFF; dir_in = 2'b00; mode_in = 4'b0101;
        @(negedge clk_50M);
        load = 1'b0;
        chk("estop_load_ack", load_ack, 0);
        chk("estop_load_a", pwm_a, 2'b11);
        chk("estop_load_b", pwm_b, 2'b11);
        estop = 1'b0;
        @(negedge clk_50M);
        chk("estop_load_ack2", load_ack, 0);
        wait_tick();
        chk("estop_load_ignored_duty", duty_cur, 0);
        chk("estop_load_ignored_a", pwm_a, 0);
        do_load(8'h02, 2'b00, 4'b0001);
        wait_tick();
        chk("after_release_duty", duty_cur[3:0], 1);
        chk("after_release_a", pwm_a[0], 1);
        chk("after_release_busy", busy, 1);
        reset = 1'b1; estop = 1'b1; load = 1'b1; duty_in = 8'hFF; mode_in = 4'b0101;
        @(negedge clk_50M);
        chk("midrst_a", pwm_a, 0);
        chk("midrst_b", pwm_b, 0);
        chk("midrst_duty", duty_cur, 0);
        chk("midrst_ack", load_ack, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_tick", period_tick, 0);
        reset = 1'b0; estop = 1'b0; load = 1'b0;
        @(negedge clk_50M);
        chk("postrst_ack", load_ack, 0);
        wait_tick();
        chk("postrst_duty", duty_cur, 0);
        chk("postrst_a", pwm_a, 0);
        b_duty = 32'h00FF_0000; b_mode = 8'b0001_0000; b_dir = 4'b0000; b_load = 1'b1;
        @(negedge clk_50M);
        b_load = 1'b0;
        chk("big_ack", b_ack, 1);
        for (int v = 1; v <= 16; v++) bq.push_back(v == 16 ? 255 : 16 * v);
        n = 0;
        while (!b_tick && n < 600) begin
            @(negedge clk_50M);
            n++;
        end
        chk("big_first_tick", b_tick, 1);
        while (bq.size() > 0) begin
            ev = bq.pop_front();
            @(negedge clk_50M);
            chk("big_duty", b_cur[23:16], ev);
            hi = 0;
            for (int c = 0; c < 510; c++) begin
                if (b_a[2]) hi++;
                if (c < 509) @(negedge clk_50M);
            end
            chk("big_tick_align", b_tick, 1);
            chk("big_pulse_width", hi, ev * 2);
        end
        chk("big_busy", b_busy, 0);
        chk("big_b", b_b, 0);
        chk("big_other_a", b_a & 4'b1011, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/motor_pwm_array.md
MOTOR_PWM_ARRAY -- requirements
Module: motor_pwm_array

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of motor channels (1..8).
REQ-002 SHALL have parameter DUTY_W, default 4: duty width in bits; PWM period = 2^DUTY_W-1 ticks.
REQ-003 SHALL have parameter PRESCALE, default 16: clk_50M cycles per PWM tick (>=2).
REQ-004 SHALL have parameter RAMP_STEP, default 1: duty change per period during ramping (>=1).
REQ-005 SHALL have port clk_50M  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port duty_in  in  N_CH*DUTY_W  target duty per channel; channel k at bits [k*DUTY_W +: DUTY_W].
REQ-008 SHALL have port dir_in  in  N_CH  target direction per channel (0 fwd, 1 rev).
REQ-009 SHALL have port mode_in  in  2*N_CH  per-channel mode: 00 coast, 01 drive, 10 brake, 11 treated as coast.
REQ-010 SHALL have port load  in  1  single-cycle strobe capturing duty_in/dir_in/mode_in.
REQ-011 SHALL have port estop  in  1  level emergency stop (ultrasonic fault).
REQ-012 SHALL have port load_ack  out  1  one-cycle pulse, cycle after an accepted load.
REQ-013 SHALL have port pwm_a  out  N_CH  bridge input A per channel.
REQ-014 SHALL have port pwm_b  out  N_CH  bridge input B per channel.
REQ-015 SHALL have port duty_cur  out  N_CH*DUTY_W  duty currently applied per channel.
REQ-016 SHALL have port period_tick  out  1  one-cycle pulse at every PWM period wrap.
REQ-017 SHALL have port busy  out  1  high while any channel is not settled at its target.

Function
REQ-018 SHALL count prescaler 0..PRESCALE-1; a tick occurs on wrap to 0.
REQ-019 SHALL advance period counter 0..2^DUTY_W-2 on each tick; period_tick pulses on the clk_50M cycle the counter wraps to 0.
REQ-020 SHALL assert raw PWM for a channel while period counter < duty_cur; duty 0 never high, duty 2^DUTY_W-1 always high.
REQ-021 SHALL map outputs: drive dir 0 -> a=PWM,b=0; drive dir 1 -> a=0,b=PWM; coast -> a=0,b=0; brake -> a=1,b=1.
REQ-022 SHALL never drive a=PWM and b=PWM simultaneously in drive mode.
REQ-023 SHALL capture load into shadow registers; a second load before the next period_tick overwrites (latest wins), each acked.
REQ-024 SHALL transfer shadow to target only on period_tick, never mid-period.
REQ-025 SHALL per channel run FSM SETTLED, RAMP_UP, RAMP_DN, REVERSE; transitions evaluated only on period_tick.
REQ-026 SHALL in RAMP_UP/RAMP_DN move duty_cur toward target by RAMP_STEP, saturating exactly at target, then SETTLED.
REQ-027 SHALL on direction change with duty_cur>0 enter REVERSE: ramp to 0, switch dir, then RAMP_UP to target; dir switches only at duty_cur=0.
REQ-028 SHALL apply coast and brake mode changes at the transfer period_tick with duty_cur forced to 0.
REQ-029 SHALL on estop, from next edge: all channels brake, duty_cur=0, targets and shadows cleared, FSMs SETTLED; held while estop high.
REQ-030 SHALL after estop release hold all channels coast until a new load.
REQ-031 SHALL ignore load coincident with or during estop (no ack).
REQ-032 SHALL derive busy combinationally from FSM states (any not SETTLED).

Reset
REQ-033 SHALL on reset clear counters, shadows, targets, duty_cur=0, dir=0, mode coast, FSMs SETTLED; pwm_a=pwm_b=0, load_ack=0, period_tick=0, busy=0; reset overrides estop and load, including mid-ramp.

Structure
REQ-034 SHALL place mode encoding and FSM state enum in package motor_pwm_pkg.
REQ-035 SHALL implement per-channel shadow/FSM/ramp/output mapping in sub-module pwm_channel, instantiated N_CH times; prescaler and period counter shared.

Verification (defaults: period 15 ticks = 240 clk_50M)
REQ-036 SHALL cover: reset, load duty 0xF fwd drive ch0 -> load_ack next cycle, duty_cur 1..15 over 15 periods, then pwm_a[0] constant 1, pwm_b[0]=0.
REQ-037 SHALL cover: ch1 settled duty 8 fwd, load duty 4 rev -> duty_cur 7..0, dir flips at 0, then 1..4 reverse; pwm_a/pwm_b never both high.
REQ-038 SHALL cover: estop mid-ramp at duty 6 -> next cycle pwm_a=pwm_b=all 1, duty_cur=0; release -> both 0 until load.
REQ-039 SHALL cover: load and estop same cycle -> no load_ack, channels brake.
REQ-040 SHALL cover: two loads (duty 3 then 9) within one period -> target 9 applied at next period_tick, two acks.
REQ-041 SHALL cover: N_CH=4, DUTY_W=8, RAMP_STEP=16 -> duty 0->255 saturates at 255 after 16 periods, pulse width equals duty_cur ticks.
